// File: rtl/qs_pkg.sv
// rtl/qs_pkg.sv - shared defaults, types and helpers for the sort-engine bank arbiter
package qs_pkg;

  localparam int QS_P       = 3;
  localparam int QS_BANKS_N = 4;
  localparam int QS_W       = 32;
  localparam int QS_N       = 256;
  localparam int QS_ST_W    = 4;
  localparam int QS_BW      = $clog2(QS_BANKS_N);
  localparam int QS_AW      = $clog2(QS_N);

  typedef logic [QS_BW-1:0]   bank_id_t;
  typedef logic [QS_AW-1:0]   addr_t;
  typedef logic [QS_W-1:0]    w_t;
  typedef logic [QS_ST_W-1:0] bank_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qs_rr_arb.sv
// rtl/qs_rr_arb.sv - P-wide pointer round-robin arbiter with fixed-priority bypass
module qs_rr_arb
  import qs_pkg::*;
#(
  parameter int P     = QS_P,
  parameter int RR_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [P-1:0] req,
  output logic [P-1:0] gnt
);

  localparam int PW = idx_w(P);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Scan starts at the pointer (or port 0 in fixed-priority mode) and wraps modulo P.
  always_comb begin
    int            start;
    logic [PW-1:0] idx;
    logic          found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    start = (RR_EN != 0) ? int'(ptr_q) : 0;
    for (int i = 0; i < P; i++) begin
      idx = PW'((start + i) % P);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        if (RR_EN != 0) begin
          ptr_d = PW'((int'(idx) + 1) % P);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spsram.sv
// rtl/spsram.sv - single-port synchronous SRAM model, registered read data
module spsram #(
  parameter int W = 32,
  parameter int N = 256
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 wen,
  input  logic [$clog2(N)-1:0] addr,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] dout_q;

  // Array contents are deliberately not reset, matching the physical macro.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        mem_q[addr] <= din;
      end else begin
        dout_q <= mem_q[addr];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/qs_bank_arb.sv
// rtl/qs_bank_arb.sv - P requesters sharing BANKS_N single-port banks plus per-bank state
module qs_bank_arb
  import qs_pkg::*;
#(
  parameter int                P       = QS_P,
  parameter int                BANKS_N = QS_BANKS_N,
  parameter int                W       = QS_W,
  parameter int                N       = QS_N,
  parameter int                ST_W    = QS_ST_W,
  parameter logic [ST_W-1:0]   ST_RST  = '0,
  parameter int                RR_EN   = 1,
  localparam int               AW      = $clog2(N),
  localparam int               BW      = $clog2(BANKS_N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P-1:0]            req_vld,
  output logic [P-1:0]            req_rdy,
  input  logic [P-1:0]            req_wen,
  input  logic [P*BW-1:0]         req_bank,
  input  logic [P*AW-1:0]         req_addr,
  input  logic [P*W-1:0]          req_wdata,
  output logic [P-1:0]            rsp_vld,
  output logic [P*W-1:0]          rsp_data,
  input  logic [P-1:0]            st_upd_vld,
  input  logic [P*BW-1:0]         st_upd_bank,
  input  logic [P*ST_W-1:0]       st_upd_data,
  output logic                    st_conflict,
  output logic [BANKS_N*ST_W-1:0] bank_state
);

  localparam int PW = idx_w(P);

  logic [P-1:0]         cand [BANKS_N];
  logic [P-1:0]         gnt  [BANKS_N];
  logic [BANKS_N-1:0]   ram_en;
  logic [BANKS_N-1:0]   ram_wen;
  logic [AW-1:0]        ram_addr [BANKS_N];
  logic [W-1:0]         ram_din  [BANKS_N];
  logic [W-1:0]         ram_dout [BANKS_N];

  logic [BANKS_N-1:0]   s1_vld_q, s1_vld_d;
  logic [PW-1:0]        s1_port_q [BANKS_N];
  logic [PW-1:0]        s1_port_d [BANKS_N];
  logic [P-1:0]         rsp_vld_q, rsp_vld_d;
  logic [P*W-1:0]       rsp_data_q, rsp_data_d;
  logic [BANKS_N*ST_W-1:0] bank_state_q, bank_state_d;
  logic                 st_conflict_q, st_conflict_d;

  always_comb begin
    for (int b = 0; b < BANKS_N; b++) begin
      for (int p = 0; p < P; p++) begin
        cand[b][p] = req_vld[p] && (req_bank[p*BW +: BW] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
    qs_rr_arb #(
      .P     (P),
      .RR_EN (RR_EN)
    ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (cand[b]),
      .gnt   (gnt[b])
    );

    spsram #(
      .W (W),
      .N (N)
    ) u_ram (
      .clk  (clk),
      .en   (ram_en[b]),
      .wen  (ram_wen[b]),
      .addr (ram_addr[b]),
      .din  (ram_din[b]),
      .dout (ram_dout[b])
    );
  end

  always_comb begin
    req_rdy = '0;
    for (int b = 0; b < BANKS_N; b++) begin
      req_rdy = req_rdy | gnt[b];
    end
  end

  // Each read is tagged with its winning port so the return path never looks at req_bank.
  always_comb begin
    for (int b = 0; b < BANKS_N; b++) begin
      ram_en[b]    = |gnt[b];
      ram_wen[b]   = 1'b0;
      ram_addr[b]  = '0;
      ram_din[b]   = '0;
      s1_vld_d[b]  = 1'b0;
      s1_port_d[b] = '0;
      for (int p = 0; p < P; p++) begin
        if (gnt[b][p]) begin
          ram_wen[b]   = req_wen[p];
          ram_addr[b]  = req_addr[p*AW +: AW];
          ram_din[b]   = req_wdata[p*W +: W];
          s1_vld_d[b]  = !req_wen[p];
          s1_port_d[b] = PW'(p);
        end
      end
    end
  end

  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    for (int b = 0; b < BANKS_N; b++) begin
      for (int p = 0; p < P; p++) begin
        if (s1_vld_q[b] && (s1_port_q[b] == PW'(p))) begin
          rsp_vld_d[p]          = 1'b1;
          rsp_data_d[p*W +: W]  = ram_dout[b];
        end
      end
    end
  end

  // State updates: lowest port wins per bank, any further hit on that bank is dropped.
  always_comb begin
    logic taken;
    taken         = 1'b0;
    bank_state_d  = bank_state_q;
    st_conflict_d = 1'b0;
    for (int b = 0; b < BANKS_N; b++) begin
      taken = 1'b0;
      for (int p = 0; p < P; p++) begin
        if (st_upd_vld[p] && (st_upd_bank[p*BW +: BW] == BW'(b))) begin
          if (!taken) begin
            bank_state_d[b*ST_W +: ST_W] = st_upd_data[p*ST_W +: ST_W];
            taken = 1'b1;
          end else begin
            st_conflict_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q      <= '0;
      rsp_vld_q     <= '0;
      rsp_data_q    <= '0;
      bank_state_q  <= {BANKS_N{ST_RST}};
      st_conflict_q <= 1'b0;
      for (int b = 0; b < BANKS_N; b++) begin
        s1_port_q[b] <= '0;
      end
    end else begin
      s1_vld_q      <= s1_vld_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_data_q    <= rsp_data_d;
      bank_state_q  <= bank_state_d;
      st_conflict_q <= st_conflict_d;
      for (int b = 0; b < BANKS_N; b++) begin
        s1_port_q[b] <= s1_port_d[b];
      end
    end
  end

  assign rsp_vld     = rsp_vld_q;
  assign rsp_data    = rsp_data_q;
  assign bank_state  = bank_state_q;
  assign st_conflict = st_conflict_q;

endmodule

// File: tb/tb_qs_bank_arb.sv
// tb/tb_qs_bank_arb.sv - bench for qs_bank_arb, round-robin and fixed-priority instances
module tb_qs_bank_arb;

  localparam int P  = 3;
  localparam int BN = 4;
  localparam int W  = 32;
  localparam int N  = 256;
  localparam int SW = 4;
  localparam int BW = 2;
  localparam int AW = 8;

  logic clk;
  logic rst_n;

  logic [P-1:0]     req_vld     [2];
  logic [P-1:0]     req_rdy     [2];
  logic [P-1:0]     req_wen     [2];
  logic [P*BW-1:0]  req_bank    [2];
  logic [P*AW-1:0]  req_addr    [2];
  logic [P*W-1:0]   req_wdata   [2];
  logic [P-1:0]     rsp_vld     [2];
  logic [P*W-1:0]   rsp_data    [2];
  logic [P-1:0]     st_upd_vld  [2];
  logic [P*BW-1:0]  st_upd_bank [2];
  logic [P*SW-1:0]  st_upd_data [2];
  logic             st_conflict [2];
  logic [BN*SW-1:0] bank_state  [2];

  qs_bank_arb #(.P(P), .BANKS_N(BN), .W(W), .N(N), .ST_W(SW), .ST_RST(4'h0), .RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld[0]), .req_rdy(req_rdy[0]), .req_wen(req_wen[0]), .req_bank(req_bank[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_vld(rsp_vld[0]), .rsp_data(rsp_data[0]),
    .st_upd_vld(st_upd_vld[0]), .st_upd_bank(st_upd_bank[0]), .st_upd_data(st_upd_data[0]),
    .st_conflict(st_conflict[0]), .bank_state(bank_state[0])
  );

  qs_bank_arb #(.P(P), .BANKS_N(BN), .W(W), .N(N), .ST_W(SW), .ST_RST(4'h0), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld[1]), .req_rdy(req_rdy[1]), .req_wen(req_wen[1]), .req_bank(req_bank[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_vld(rsp_vld[1]), .rsp_data(rsp_data[1]),
    .st_upd_vld(st_upd_vld[1]), .st_upd_bank(st_upd_bank[1]), .st_upd_data(st_upd_data[1]),
    .st_conflict(st_conflict[1]), .bank_state(bank_state[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: per-DUT memory image, pointers, state and a queue of due responses.
  typedef struct {
    int           d;
    int           p;
    int           due;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t          rq [$];
  int            ptr_m  [2][BN];
  logic [W-1:0]  mem_m  [2][BN][N];
  logic [SW-1:0] bst_m  [2][BN];
  logic          conf_m [2];
  logic [W-1:0]  rdat_m [2][P];
  logic [P-1:0]  gnt_m  [2];

  typedef struct {
    logic [P-1:0]    vld;
    logic [P*BW-1:0] bank;
    logic [P*SW-1:0] data;
    int              eb;
    logic [SW-1:0]   ev;
    logic            ec;
  } st_vec_t;

  st_vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int b, input int a);
    return W'(32'hB000_0000 + b * 256 + a);
  endfunction

  task automatic model_reset(input int d);
    for (int b = 0; b < BN; b++) begin
      ptr_m[d][b] = 0;
      bst_m[d][b] = '0;
    end
    for (int p = 0; p < P; p++) rdat_m[d][p] = '0;
    conf_m[d] = 1'b0;
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].d == d) rq.delete(i);
  endtask

  function automatic logic [P-1:0] model_gnt(input int d);
    logic [P-1:0] g = '0;
    for (int b = 0; b < BN; b++) begin
      int start = (d == 0) ? ptr_m[d][b] : 0;
      for (int k = 0; k < P; k++) begin
        int p = (start + k) % P;
        if (req_vld[d][p] && int'(req_bank[d][p*BW +: BW]) == b) begin
          g[p] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic check_dut(input int d);
    logic [P-1:0]     ev = '0;
    logic [P*W-1:0]   ed;
    logic [BN*SW-1:0] es;
    gnt_m[d] = model_gnt(d);
    chk($sformatf("req_rdy[dut%0d]", d), 128'(req_rdy[d]), 128'(gnt_m[d]));
    foreach (rq[i]) begin
      if (rq[i].d == d && rq[i].due == cyc) begin
        ev[rq[i].p] = 1'b1;
        rdat_m[d][rq[i].p] = rq[i].data;
      end
    end
    for (int p = 0; p < P; p++) ed[p*W +: W] = rdat_m[d][p];
    for (int b = 0; b < BN; b++) es[b*SW +: SW] = bst_m[d][b];
    chk($sformatf("rsp_vld[dut%0d]", d), 128'(rsp_vld[d]), 128'(ev));
    chk($sformatf("rsp_data[dut%0d]", d), 128'(rsp_data[d]), 128'(ed));
    chk($sformatf("bank_state[dut%0d]", d), 128'(bank_state[d]), 128'(es));
    chk($sformatf("st_conflict[dut%0d]", d), 128'(st_conflict[d]), 128'(conf_m[d]));
  endtask

  task automatic advance(input int d);
    if (!rst_n) begin
      model_reset(d);
      return;
    end
    for (int p = 0; p < P; p++) begin
      if (gnt_m[d][p]) begin
        int b = int'(req_bank[d][p*BW +: BW]);
        int a = int'(req_addr[d][p*AW +: AW]);
        if (req_wen[d][p]) mem_m[d][b][a] = req_wdata[d][p*W +: W];
        else rq.push_back('{d, p, cyc + 2, mem_m[d][b][a]});
        if (d == 0) ptr_m[d][b] = (p + 1) % P;
      end
    end
    conf_m[d] = 1'b0;
    for (int b = 0; b < BN; b++) begin
      bit taken = 0;
      for (int p = 0; p < P; p++) begin
        if (st_upd_vld[d][p] && int'(st_upd_bank[d][p*BW +: BW]) == b) begin
          if (!taken) begin
            bst_m[d][b] = st_upd_data[d][p*SW +: SW];
            taken = 1;
          end else begin
            conf_m[d] = 1'b1;
          end
        end
      end
    end
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].d == d && rq[i].due <= cyc) rq.delete(i);
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) check_dut(d);
    for (int d = 0; d < 2; d++) advance(d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    tick();
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      req_vld[d] = '0; req_wen[d] = '0; req_bank[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
      st_upd_vld[d] = '0; st_upd_bank[d] = '0; st_upd_data[d] = '0;
    end
  endtask

  task automatic set_req(input int d, input int p, input bit v, input bit we, input int b,
                         input int a, input logic [W-1:0] wd);
    req_vld[d][p]            = v;
    req_wen[d][p]            = we;
    req_bank[d][p*BW +: BW]  = BW'(b);
    req_addr[d][p*AW +: AW]  = AW'(a);
    req_wdata[d][p*W +: W]   = wd;
  endtask

  initial begin
    int   cnt [2][P];
    bit   pend [2][P];
    logic [P-1:0] e;

    tbl[0] = '{3'b101, {2'd3, 2'd0, 2'd3}, {4'h9, 4'h0, 4'h5}, 3, 4'h5, 1'b1};
    tbl[1] = '{3'b010, {2'd0, 2'd1, 2'd0}, {4'h0, 4'hA, 4'h0}, 1, 4'hA, 1'b0};
    tbl[2] = '{3'b111, {2'd2, 2'd1, 2'd0}, {4'h3, 4'h2, 4'h1}, 2, 4'h3, 1'b0};
    tbl[3] = '{3'b110, {2'd2, 2'd2, 2'd0}, {4'h8, 4'h7, 4'h0}, 2, 4'h7, 1'b1};
    tbl[4] = '{3'b011, {2'd0, 2'd3, 2'd3}, {4'h0, 4'hD, 4'hC}, 3, 4'hC, 1'b1};
    tbl[5] = '{3'b100, {2'd2, 2'd0, 2'd0}, {4'hF, 4'h0, 4'h0}, 2, 4'hF, 1'b0};

    rst_n = 1'b0;
    idle_all();
    for (int d = 0; d < 2; d++) model_reset(d);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset bank_state", 128'(bank_state[d]), 128'(0));
      chk("reset rsp_vld", 128'(rsp_vld[d]), 128'(0));
      chk("reset st_conflict", 128'(st_conflict[d]), 128'(0));
    end
    tick();

    for (int b = 0; b < BN; b++) begin
      for (int a = 0; a < 8; a++) begin
        idle_all();
        for (int d = 0; d < 2; d++) set_req(d, 0, 1, 1, b, a, pat(b, a));
        step();
      end
    end

    // Write then read back through port 1 on bank 2.
    idle_all();
    for (int d = 0; d < 2; d++) set_req(d, 1, 1, 1, 2, 5, 32'h0000_A5A5);
    #1;
    for (int d = 0; d < 2; d++) chk("wr rdy p1", 128'(req_rdy[d]), 128'(3'b010));
    tick();
    idle_all();
    for (int d = 0; d < 2; d++) set_req(d, 1, 1, 0, 2, 5, '0);
    #1;
    for (int d = 0; d < 2; d++) chk("rd rdy p1", 128'(req_rdy[d]), 128'(3'b010));
    tick();
    idle_all();
    #1;
    for (int d = 0; d < 2; d++) chk("rd latency T+1", 128'(rsp_vld[d]), 128'(0));
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rd latency T+2", 128'(rsp_vld[d]), 128'(3'b010));
      chk("rd data p1", 128'(rsp_data[d][W +: W]), 128'(32'h0000_A5A5));
    end
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rsp_vld one cycle", 128'(rsp_vld[d]), 128'(0));
      chk("rsp_data hold", 128'(rsp_data[d][W +: W]), 128'(32'h0000_A5A5));
    end
    tick();

    // Three ports on three banks in the same cycle.
    idle_all();
    for (int d = 0; d < 2; d++) for (int p = 0; p < P; p++) set_req(d, p, 1, 0, p, 1, '0);
    #1;
    for (int d = 0; d < 2; d++) chk("parallel rdy", 128'(req_rdy[d]), 128'(3'b111));
    tick();
    idle_all();
    step();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("parallel rsp_vld", 128'(rsp_vld[d]), 128'(3'b111));
      chk("parallel rsp_data", 128'(rsp_data[d]), 128'({pat(2, 1), pat(1, 1), pat(0, 1)}));
    end
    tick();

    foreach (tbl[i]) begin
      idle_all();
      for (int d = 0; d < 2; d++) begin
        st_upd_vld[d] = tbl[i].vld; st_upd_bank[d] = tbl[i].bank; st_upd_data[d] = tbl[i].data;
      end
      step();
      idle_all();
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("st row%0d state", i), 128'(bank_state[d][tbl[i].eb*SW +: SW]), 128'(tbl[i].ev));
        chk($sformatf("st row%0d conflict", i), 128'(st_conflict[d]), 128'(tbl[i].ec));
      end
      tick();
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("st row%0d conflict pulse", i), 128'(st_conflict[d]), 128'(0));
      tick();
    end

    // Reset lands the cycle after a read is accepted.
    idle_all();
    for (int d = 0; d < 2; d++) set_req(d, 0, 1, 0, 0, 2, '0);
    step();
    rst_n = 1'b0;
    idle_all();
    for (int d = 0; d < 2; d++) model_reset(d);
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("post-reset rsp_vld", 128'(rsp_vld[d]), 128'(0));
      chk("post-reset bank_state", 128'(bank_state[d]), 128'(0));
    end
    tick();

    for (int d = 0; d < 2; d++) for (int p = 0; p < P; p++) cnt[d][p] = 0;
    for (int k = 0; k < 11; k++) begin
      idle_all();
      if (k < 9) for (int d = 0; d < 2; d++) for (int p = 0; p < P; p++) set_req(d, p, 1, 0, 0, 3, '0);
      #1;
      for (int d = 0; d < 2; d++) for (int p = 0; p < P; p++) cnt[d][p] += int'(rsp_vld[d][p]);
      if (k < 9) begin
        e = P'(1 << (k % 3));
        chk($sformatf("rr rotate k%0d", k), 128'(req_rdy[0]), 128'(e));
        chk($sformatf("fp prio k%0d", k), 128'(req_rdy[1]), 128'(3'b001));
      end
      tick();
    end
    for (int p = 0; p < P; p++) begin
      chk($sformatf("rr rsp count p%0d", p), 128'(cnt[0][p]), 128'(3));
      chk($sformatf("fp rsp count p%0d", p), 128'(cnt[1][p]), 128'((p == 0) ? 9 : 0));
    end

    idle_all();
    for (int d = 0; d < 2; d++) for (int p = 0; p < P; p++) pend[d][p] = 0;
    for (int it = 0; it < 3000; it++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < P; p++) begin
          if (!pend[d][p]) begin
            if ($urandom_range(3) != 0) begin
              set_req(d, p, 1, $urandom_range(2) == 0, int'($urandom_range(BN - 1)),
                      int'($urandom_range(7)), $urandom);
              pend[d][p] = 1;
            end else begin
              req_vld[d][p] = 1'b0;
            end
          end
          st_upd_vld[d][p]          = ($urandom_range(3) == 0);
          st_upd_bank[d][p*BW +: BW] = BW'($urandom_range(BN - 1));
          st_upd_data[d][p*SW +: SW] = SW'($urandom_range(15));
        end
      end
      step();
      for (int d = 0; d < 2; d++) for (int p = 0; p < P; p++) if (gnt_m[d][p]) pend[d][p] = 0;
    end
    idle_all();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
